wor_bus_arbiter: RTL and testbench
==================================

WOR_BUS_ARBITER -- requirements
Module: wor_bus_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, SHALL set the number of requesters sharing the output bus.
REQ-002 Parameter DW, default 3, SHALL set the payload width per beat.
REQ-003 Parameter MAX_BEATS, default 8, SHALL set the maximum beats per grant before forced release.
REQ-004 clk  input  1  SHALL be the single rising-edge clock.
REQ-005 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-006 req  input  [N_REQ]  SHALL carry the per-requester request, one bit per requester.
REQ-007 req_data  input  [N_REQ][DW]  SHALL carry the per-requester payload.
REQ-008 req_last  input  [N_REQ]  SHALL carry the per-requester end-of-burst flag.
REQ-009 gnt  output  [N_REQ]  SHALL be one-hot or zero, and SHALL mark the requester owning the bus.
REQ-010 bus_valid  output  1  SHALL flag a valid beat on the bus.
REQ-011 bus_data  output  [DW]  SHALL carry the payload of the granted requester.
REQ-012 bus_src  output  [clog2(N_REQ)]  SHALL carry the index of the granted requester.
REQ-013 bus_ready  input  1  SHALL be the sink acceptance; a beat transfers when bus_valid and bus_ready are both high.
REQ-014 forced_rel  output  1  SHALL pulse for one cycle when a grant is revoked by the MAX_BEATS limit.

Function
REQ-015 The FSM SHALL have the states IDLE and OWN.
REQ-016 In IDLE, with any req bit high, the arbiter SHALL select the first requester at or after ptr in round-robin order (wrapping from N_REQ-1 to 0), register gnt, and enter OWN on the next edge.
REQ-017 In IDLE with no req bit high, gnt SHALL be zero and the arbiter SHALL stay in IDLE.
REQ-018 In OWN, bus_valid SHALL equal req of the granted requester.
REQ-019 In OWN, bus_data and bus_src SHALL reflect the granted requester combinationally (zero latency from req_data).
REQ-020 When bus_valid is low, bus_data SHALL be zero.
REQ-021 A beat counter SHALL clear on grant and SHALL increment on each transfer, saturating at MAX_BEATS.
REQ-022 On a transfer with req_last high, the arbiter SHALL release the grant: return to IDLE, clear gnt, and set ptr to the granted index + 1 modulo N_REQ.
REQ-023 On a transfer that brings the count to MAX_BEATS without last, the arbiter SHALL release as in REQ-022 and SHALL assert forced_rel for that cycle.
REQ-024 When last and the MAX_BEATS limit coincide on the same transfer, the release SHALL be treated as normal, with forced_rel low.
REQ-025 The granted requester dropping req mid-burst SHALL NOT release the grant; only last or the beat limit SHALL release.
REQ-026 Release to IDLE SHALL cost exactly one idle cycle before the next grant; back-to-back grant in the release cycle SHALL NOT occur.
REQ-027 req changes of non-granted requesters SHALL NOT affect the current grant.
REQ-028 With N_REQ=1, ptr SHALL stay 0 and behaviour SHALL otherwise be identical.

Reset
REQ-029 Asserting rst at any time, including mid-burst, SHALL force state to IDLE, gnt to 0, ptr to 0, the beat count to 0, and forced_rel to 0.
REQ-030 While rst is high, bus_valid and bus_data SHALL be 0.
REQ-031 The first grant after reset deassertion SHALL occur no earlier than the second rising edge.

Structure
REQ-032 The FSM state enum and a clog2-based index-width function SHALL live in the shared package wor_bus_pkg.
REQ-033 Round-robin selection SHALL be a combinational sub-module rr_pick (inputs req and ptr; outputs one-hot grant and index).

Verification
REQ-034 Reset, then req=4'b0001 with last on the first transfer and bus_ready=1 -> gnt=0001 after one cycle, one beat with bus_src=0, then IDLE.
REQ-035 req=4'b1111 with every burst one beat long -> grant order 0,1,2,3,0, with one idle cycle between grants.
REQ-036 Requester 2 never sets last, MAX_BEATS=8 -> release after 8 transfers, forced_rel high for one cycle, next grant to 3.
REQ-037 bus_ready=0 for 5 cycles mid-burst -> beat count frozen, grant held, bus_data stable.
REQ-038 rst asserted during beat 3 of a burst -> gnt=0 immediately (asynchronous), next grant to requester 0.
REQ-039 last coincident with the 8th transfer -> release with forced_rel low.

Source files
------------

// File: rtl/wor_bus_pkg.sv
// Shared types and helpers for the wired-OR bus arbiter.
// Holds the arbiter FSM encoding and the index-width function used for port sizing.
package wor_bus_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_e;

    // Width of an index into n items; never below one bit, so N_REQ=1 still has a real ptr.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/wor_bus_rr_pick.sv
// Combinational round-robin picker: first asserted requester at or after ptr,
// wrapping from N_REQ-1 back to 0. Outputs a one-hot grant and its index.
module rr_pick
    import wor_bus_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]          req,
    input  logic [idx_w(N_REQ)-1:0]   ptr,
    output logic [N_REQ-1:0]          gnt,
    output logic [idx_w(N_REQ)-1:0]   idx
);

    localparam int IW = idx_w(N_REQ);

    logic [IW-1:0] cand;
    logic          found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = IW'((int'(ptr) + i) % N_REQ);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/wor_bus_arbiter.sv
// Round-robin arbiter for a shared output bus: one requester owns the bus until
// it signals last on a transfer or reaches MAX_BEATS transfers (forced release).
module wor_bus_arbiter
    import wor_bus_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int DW        = 3,
    parameter int MAX_BEATS = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ-1:0][DW-1:0]    req_data,
    input  logic [N_REQ-1:0]            req_last,
    output logic [N_REQ-1:0]            gnt,
    output logic                        bus_valid,
    output logic [DW-1:0]               bus_data,
    output logic [idx_w(N_REQ)-1:0]     bus_src,
    input  logic                        bus_ready,
    output logic                        forced_rel,
    output logic                        dbg_state
);

    // Handshake: a beat moves when bus_valid && bus_ready at a rising edge;
    // bus_valid follows the owner's req, and the sink may stall with bus_ready low.

    localparam int IW = idx_w(N_REQ);
    localparam int CW = idx_w(MAX_BEATS + 1);

    arb_state_e        state;
    logic              armed;
    logic [IW-1:0]     ptr;
    logic [IW-1:0]     idx;
    logic [IW-1:0]     ptr_next;
    logic [IW-1:0]     pick_idx;
    logic [N_REQ-1:0]  pick_gnt;
    logic [CW-1:0]     beats;
    logic [CW-1:0]     beats_inc;
    logic              xfer;
    logic              last_beat;
    logic              limit_hit;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req (req),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    // Bus mux is combinational from the owner's inputs; quiet while in reset or idle.
    always_comb begin
        bus_valid = 1'b0;
        bus_data  = '0;
        bus_src   = '0;
        if (!rst && state == OWN) begin
            bus_src   = idx;
            bus_valid = req[idx];
            if (req[idx]) begin
                bus_data = req_data[idx];
            end
        end
    end

    assign xfer      = bus_valid & bus_ready;
    assign last_beat = req_last[idx];
    assign beats_inc = (beats == CW'(MAX_BEATS)) ? beats : beats + 1'b1;
    assign limit_hit = (beats_inc == CW'(MAX_BEATS));
    assign ptr_next  = (idx == IW'(N_REQ - 1)) ? '0 : idx + 1'b1;
    assign dbg_state = state;

    // armed holds off the first grant until the second edge after reset release.
    // forced_rel is registered, so it is high during the idle cycle after the limit release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            armed      <= 1'b0;
            gnt        <= '0;
            ptr        <= '0;
            idx        <= '0;
            beats      <= '0;
            forced_rel <= 1'b0;
        end else begin
            armed      <= 1'b1;
            forced_rel <= 1'b0;
            case (state)
                IDLE: begin
                    if (armed && |req) begin
                        gnt   <= pick_gnt;
                        idx   <= pick_idx;
                        beats <= '0;
                        state <= OWN;
                    end
                end
                OWN: begin
                    if (xfer) begin
                        beats <= beats_inc;
                        if (last_beat || limit_hit) begin
                            state      <= IDLE;
                            gnt        <= '0;
                            ptr        <= ptr_next;
                            forced_rel <= !last_beat;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wor_bus_arbiter.sv
// Directed bench for wor_bus_arbiter (N_REQ=4, DW=3, MAX_BEATS=8).
module tb_wor_bus_arbiter;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [3:0]       req = '0;
  logic [3:0][2:0]  req_data = '0;
  logic [3:0]       req_last = '0;
  logic [3:0]       gnt;
  logic             bus_valid;
  logic [2:0]       bus_data;
  logic [1:0]       bus_src;
  logic             bus_ready = 1'b1;
  logic             forced_rel;
  logic             dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  // clock / reset block
  always #5 clk = ~clk;

  wor_bus_arbiter #(
    .N_REQ     (4),
    .DW        (3),
    .MAX_BEATS (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_data   (req_data),
    .req_last   (req_last),
    .gnt        (gnt),
    .bus_valid  (bus_valid),
    .bus_data   (bus_data),
    .bus_src    (bus_src),
    .bus_ready  (bus_ready),
    .forced_rel (forced_rel),
    .dbg_state  (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    req_last = '0;
    bus_ready = 1'b1;
    #1;
    check("rst_gnt", gnt, 0);
    check("rst_valid", bus_valid, 0);
    check("rst_data", bus_data, 0);
    check("rst_frel", forced_rel, 0);
    check("rst_state", dbg_state, 0);
    step();
    rst = 1'b0;
    step();
  endtask

  int order[5] = '{0, 1, 2, 3, 0};

  initial begin
    // single one-beat burst; first grant only on second edge after reset
    rst = 1'b1;
    req = 4'b0001;
    req_last = 4'b0001;
    req_data = {3'd0, 3'd0, 3'd0, 3'd5};
    #1;
    check("t1_rst_gnt", gnt, 0);
    check("t1_rst_valid", bus_valid, 0);
    check("t1_rst_data", bus_data, 0);
    step();
    rst = 1'b0;
    step();
    check("t1_first_edge_gnt", gnt, 0);
    step();
    check("t1_gnt", gnt, 4'b0001);
    check("t1_valid", bus_valid, 1);
    check("t1_src", bus_src, 0);
    check("t1_data", bus_data, 5);
    check("t1_state", dbg_state, 1);
    step();
    check("t1_rel_gnt", gnt, 0);
    check("t1_rel_state", dbg_state, 0);
    check("t1_rel_frel", forced_rel, 0);
    req = '0;
    step();
    check("t1_idle_gnt", gnt, 0);
    check("t1_idle_valid", bus_valid, 0);

    // all requesting, one-beat bursts: 0,1,2,3,0 with an idle cycle between
    do_reset();
    req = 4'b1111;
    req_last = 4'b1111;
    req_data = {3'd4, 3'd3, 3'd2, 3'd1};
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("t2_gnt%0d", k), gnt, 32'(1) << order[k]);
      check($sformatf("t2_src%0d", k), bus_src, order[k]);
      check($sformatf("t2_data%0d", k), bus_data, order[k] + 1);
      step();
      check($sformatf("t2_gap%0d", k), gnt, 0);
      check($sformatf("t2_gapv%0d", k), bus_valid, 0);
    end
    req = '0;

    // requester 2 never sets last: forced release after 8 transfers, then 3
    do_reset();
    req = 4'b0100;
    req_last = '0;
    req_data = {3'd1, 3'd6, 3'd0, 3'd0};
    step();
    check("t3_gnt", gnt, 4'b0100);
    for (int b = 1; b <= 7; b++) begin
      if (b == 3) req = 4'b1100;
      step();
      check($sformatf("t3_hold%0d", b), gnt, 4'b0100);
      check($sformatf("t3_frel%0d", b), forced_rel, 0);
    end
    step();
    check("t3_rel_gnt", gnt, 0);
    check("t3_rel_frel", forced_rel, 1);
    req_last = 4'b1000;
    step();
    check("t3_frel_pulse", forced_rel, 0);
    check("t3_next_gnt", gnt, 4'b1000);
    check("t3_next_src", bus_src, 3);
    step();
    check("t3_done", gnt, 0);
    req = '0;
    req_last = '0;

    // sink stall and owner req drop: grant held, count frozen
    do_reset();
    req = 4'b0010;
    req_data = {3'd0, 3'd0, 3'd3, 3'd0};
    step();
    check("t4_gnt", gnt, 4'b0010);
    step();
    step();
    bus_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      step();
      check($sformatf("t4_stall_gnt%0d", s), gnt, 4'b0010);
      check($sformatf("t4_stall_data%0d", s), bus_data, 3);
    end
    bus_ready = 1'b1;
    req = 4'b0000;
    for (int s = 0; s < 2; s++) begin
      step();
      check($sformatf("t4_drop_gnt%0d", s), gnt, 4'b0010);
      check($sformatf("t4_drop_valid%0d", s), bus_valid, 0);
      check($sformatf("t4_drop_data%0d", s), bus_data, 0);
    end
    req = 4'b0010;
    for (int b = 0; b < 5; b++) begin
      step();
      check($sformatf("t4_resume%0d", b), gnt, 4'b0010);
    end
    step();
    check("t4_rel_gnt", gnt, 0);
    check("t4_rel_frel", forced_rel, 1);
    req = '0;

    // reset during beat 3 clears grant at once; next grant goes to 0
    do_reset();
    req = 4'b0100;
    req_data = {3'd0, 3'd7, 3'd0, 3'd2};
    step();
    step();
    step();
    check("t5_pre_gnt", gnt, 4'b0100);
    rst = 1'b1;
    #1;
    check("t5_async_gnt", gnt, 0);
    check("t5_async_valid", bus_valid, 0);
    check("t5_async_data", bus_data, 0);
    check("t5_async_state", dbg_state, 0);
    step();
    rst = 1'b0;
    req = 4'b0101;
    req_last = 4'b0101;
    step();
    check("t5_arm_gnt", gnt, 0);
    step();
    check("t5_gnt", gnt, 4'b0001);
    check("t5_data", bus_data, 2);
    step();
    req = '0;
    req_last = '0;

    // last coincides with 8th transfer: normal release
    do_reset();
    req = 4'b0001;
    req_data = {3'd0, 3'd0, 3'd0, 3'd6};
    step();
    check("t6_gnt", gnt, 4'b0001);
    for (int b = 1; b <= 7; b++) step();
    check("t6_hold", gnt, 4'b0001);
    req_last = 4'b0001;
    step();
    check("t6_rel_gnt", gnt, 0);
    check("t6_rel_frel", forced_rel, 0);
    check("t6_rel_state", dbg_state, 0);
    req = '0;
    req_last = '0;
    step();

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
